simple_mem_arbiter: RTL and testbench

SIMPLE_MEM_ARBITER -- requirements
Module: simple_mem_arbiter

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/simple_mem_arbiter_if.sv | 20 ++
 rtl/simple_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_simple_mem_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the instruction/data memory arbiter: response owner
// encoding, the flattened single-port memory request, and an address helper.
package riscv_pkg;

  // Who the memory read data returned this cycle belongs to.
  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INSTR = 2'd1,
    OWNER_DATA  = 2'd2
  } mem_owner_t;

  // One single-port memory request, as presented for one cycle.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  // Instruction fetches always read the whole word.
  localparam logic [3:0] BE_ALL = 4'hF;

  // Memory is word addressed; the byte offset is carried by the byte enables.
  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/simple_mem_arbiter_if.sv
// Single-port memory bus as seen between the arbiter (master) and the
// memory (slave). Read data returns one cycle after an accepted read.
interface simple_mem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata
  );
endinterface

// File: rtl/simple_mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port memory.
// Data wins ties unless the fetch port has been starved STARVE_LIMIT cycles.
// Grants are combinational; read responses are steered one cycle later by a
// registered owner tag.
module simple_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  // instruction fetch port
  input  logic        ireq_i,
  input  logic [31:0] iaddr_i,
  output logic        igrant_o,
  output logic        irvalid_o,
  output logic [31:0] irdata_o,
  input  logic        iflush_i,
  // load/store port
  input  logic        dreq_i,
  input  logic        dwe_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [3:0]  dbe_i,
  output logic        dgrant_o,
  output logic        drvalid_o,
  output logic [31:0] drdata_o,
  // memory port
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  mem_owner_t    owner_q,  owner_d;
  logic          force_instr;
  logic          igrant;
  logic          dgrant;
  mem_req_t      mreq;

  // Byte offsets are not forwarded; memory is word addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{iaddr_i[1:0], daddr_i[1:0]};

  // Pick a winner: data by default, fetch when starved or alone. Nothing is
  // granted while reset is held.
  always_comb begin
    force_instr = ireq_i && (starve_q == LIMIT);
    dgrant      = rstn_i && dreq_i && !force_instr;
    igrant      = rstn_i && ireq_i && !dgrant;
  end

  // Starvation counter: counts denied fetch cycles, saturates, clears on a
  // fetch grant or an idle fetch port.
  always_comb begin
    starve_d = starve_q;
    if (!ireq_i || igrant) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Tag the response slot of the next cycle; stores produce no response.
  always_comb begin
    owner_d = OWNER_NONE;
    if (igrant) begin
      owner_d = OWNER_INSTR;
    end else if (dgrant && !dwe_i) begin
      owner_d = OWNER_DATA;
    end
  end

  // Build the memory request for the winner; all zero when idle.
  always_comb begin
    mreq = '0;
    if (igrant) begin
      mreq.req  = 1'b1;
      mreq.we   = 1'b0;
      mreq.addr = word_align(iaddr_i);
      mreq.be   = BE_ALL;
    end else if (dgrant) begin
      mreq.req   = 1'b1;
      mreq.we    = dwe_i;
      mreq.addr  = word_align(daddr_i);
      mreq.wdata = dwdata_i;
      mreq.be    = dbe_i;
    end
  end

  // Arbitration state; reset discards any pending response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_q <= '0;
      owner_q  <= OWNER_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  assign igrant_o    = igrant;
  assign dgrant_o    = dgrant;
  assign mem_req_o   = mreq.req;
  assign mem_we_o    = mreq.we;
  assign mem_addr_o  = mreq.addr;
  assign mem_wdata_o = mreq.wdata;
  assign mem_be_o    = mreq.be;

  // Steer read data to whichever port owns this response cycle. A flushed
  // fetch response is simply dropped.
  always_comb begin
    irvalid_o = rstn_i && (owner_q == OWNER_INSTR) && !iflush_i;
    drvalid_o = rstn_i && (owner_q == OWNER_DATA);
    irdata_o  = irvalid_o ? mem_rdata_i : 32'h0;
    drdata_o  = drvalid_o ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Self-checking bench for simple_mem_arbiter: a reference model predicts
// grants and memory request each cycle, and a response queue holds the
// expected owner of the following cycle's read data.
module tb_simple_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ireq, iflush, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  dbe;
  logic        igrant, irvalid, dgrant, drvalid;
  logic [31:0] irdata, drdata;

  simple_mem_arbiter_if mem_bus ();

  simple_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .ireq_i     (ireq),
    .iaddr_i    (iaddr),
    .igrant_o   (igrant),
    .irvalid_o  (irvalid),
    .irdata_o   (irdata),
    .iflush_i   (iflush),
    .dreq_i     (dreq),
    .dwe_i      (dwe),
    .daddr_i    (daddr),
    .dwdata_i   (dwdata),
    .dbe_i      (dbe),
    .dgrant_o   (dgrant),
    .drvalid_o  (drvalid),
    .drdata_o   (drdata),
    .mem_req_o  (mem_bus.req),
    .mem_we_o   (mem_bus.we),
    .mem_addr_o (mem_bus.addr),
    .mem_wdata_o(mem_bus.wdata),
    .mem_be_o   (mem_bus.be),
    .mem_rdata_i(mem_bus.rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Model state: starvation count and queue of expected response owners
  // (0 none, 1 instr, 2 data) for the next cycle.
  int m_starve = 0;
  int own_q[$];

  // Record of fetch grants seen during the starvation run.
  logic ig_hist[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d: got=%0h want=%0h", tag, cyc_n, got, exp);
    end
  endtask

  // Drive one cycle, predict everything, compare, advance the model.
  task automatic run_cycle(input logic r, input logic i_r, input logic [31:0] i_a,
                           input logic d_r, input logic d_w, input logic [31:0] d_a,
                           input logic [31:0] d_wd, input logic [3:0] d_be,
                           input logic fl);
    logic        frc, eg_i, eg_d;
    logic [31:0] rd, e_addr;
    int          own;
    @(posedge clk);
    #1;
    cyc_n++;
    rstn = r; ireq = i_r; iaddr = i_a; dreq = d_r; dwe = d_w;
    daddr = d_a; dwdata = d_wd; dbe = d_be; iflush = fl;
    rd = $urandom;
    mem_bus.rdata = rd;

    frc  = i_r && (m_starve == LIMIT);
    eg_d = r && d_r && !frc;
    eg_i = r && i_r && !eg_d;
    e_addr = eg_i ? {i_a[31:2], 2'b00} : (eg_d ? {d_a[31:2], 2'b00} : 32'h0);
    own = (own_q.size() > 0) ? own_q.pop_front() : 0;
    if (!r) own = 0;

    #5;
    check_val("igrant",    32'(igrant),        32'(eg_i));
    check_val("dgrant",    32'(dgrant),        32'(eg_d));
    check_val("mem_req",   32'(mem_bus.req),   32'(eg_i | eg_d));
    check_val("mem_we",    32'(mem_bus.we),    32'(eg_d & d_w));
    check_val("mem_addr",  mem_bus.addr,       e_addr);
    check_val("mem_wdata", mem_bus.wdata,      eg_d ? d_wd : 32'h0);
    check_val("mem_be",    32'(mem_bus.be),    eg_i ? 32'hF : (eg_d ? 32'(d_be) : 32'h0));
    check_val("irvalid",   32'(irvalid),       32'(own == 1 && !fl));
    check_val("irdata",    irdata,             (own == 1 && !fl) ? rd : 32'h0);
    check_val("drvalid",   32'(drvalid),       32'(own == 2));
    check_val("drdata",    drdata,             (own == 2) ? rd : 32'h0);
    $display("cyc %0d rstn=%0b ireq=%0b dreq=%0b dwe=%0b -> ig=%0b dg=%0b addr=%08h irv=%0b drv=%0b",
             cyc_n, r, i_r, d_r, d_w, igrant, dgrant, mem_bus.addr, irvalid, drvalid);

    ig_hist.push_back(igrant);
    own_q.push_back(!r ? 0 : (eg_i ? 1 : ((eg_d && !d_w) ? 2 : 0)));
    if (!r || !i_r || eg_i) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
  endtask

  task automatic idle(input logic r);
    run_cycle(r, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; ireq = 0; iaddr = 0; dreq = 0; dwe = 0;
    daddr = 0; dwdata = 0; dbe = 0; iflush = 0;
    mem_bus.rdata = 32'h0;

    // Reset state, with requests active: nothing may be granted.
    idle(1'b0);
    run_cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0);
    idle(1'b1);

    // Fetch alone, then its response.
    run_cycle(1'b1, 1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    idle(1'b1);

    // Both request: load wins, data response next cycle.
    run_cycle(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
    idle(1'b1);

    // Continuous contention: fetch wins only on the 5th cycle, then 4 data.
    ig_hist.delete();
    for (int k = 0; k < 10; k++)
      run_cycle(1'b1, 1'b1, 32'h300 + 32'(4 * k), 1'b1, 1'b0, 32'h1000 + 32'(4 * k),
                32'h0, 4'hF, 1'b0);
    for (int k = 0; k < 10; k++)
      check_val("starve_seq", 32'(ig_hist[k]), 32'((k == 4) || (k == 9)));
    idle(1'b1);

    // Store at an unaligned address: aligned, byte enables passed, no response.
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2002, 32'hDEAD_BEEF, 4'b0100, 1'b0);
    idle(1'b1);

    // Fetch granted, flushed in its response cycle.
    run_cycle(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    // Reset pulse in a load's response cycle; grants possible after release.
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234, 32'h0, 4'hF, 1'b0);
    run_cycle(1'b0, 1'b1, 32'h600, 1'b1, 1'b0, 32'h1238, 32'h0, 4'hF, 1'b0);
    run_cycle(1'b1, 1'b1, 32'h604, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    idle(1'b1);

    // Random back-to-back traffic.
    for (int k = 0; k < 300; k++)
      run_cycle(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                $urandom, $urandom, 4'($urandom), 1'($urandom_range(0, 3) == 0));
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
